// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with occupancy count, registered status
// flags and a selectable read style.
//
// Parameters:
//   WIDTH    bits per word (>= 1)
//   DEPTH    words stored (power of two, >= 4)
//   AF_LEVEL almost-full threshold  (1..DEPTH-1)
//   AE_LEVEL almost-empty threshold (1..DEPTH-1)
//   FWFT     1 = first-word-fall-through, 0 = registered read data
//
// Ports:
//   clk_i, rst_ni (async, active-low), clr_i (synchronous flush)
//   wr_dv_i, wr_data_i, wr_full_o, wr_almost_full_o      write side
//   rd_en_i, rd_data_o, rd_valid_o, rd_empty_o,
//   rd_almost_empty_o                                    read side
//   count_o                                              occupancy
//   overflow_o, underflow_o                              sticky errors
//
// Optional feature: define SYNC_FIFO_ERR_FLAGS_EN to build the sticky
// overflow/underflow logic; otherwise both outputs are tied low.

module sync_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       wr_dv_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       wr_full_o,
    output logic                       wr_almost_full_o,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic                       rd_empty_o,
    output logic                       rd_almost_empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic              wr_accept;
    logic              rd_accept;

    // Acceptance uses the registered flags, so on full+both the read wins
    // and on empty+both the write wins.
    assign wr_accept = wr_dv_i && !wr_full_o;
    assign rd_accept = rd_en_i && !rd_empty_o;

    always_comb begin
        count_next = count_q;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    // Pointers, count and flags; flags are derived from the next count so
    // they move on the same edge as count_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count_q           <= '0;
            rd_empty_o        <= 1'b1;
            rd_almost_empty_o <= 1'b1;
            wr_full_o         <= 1'b0;
            wr_almost_full_o  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count_q           <= '0;
            rd_empty_o        <= 1'b1;
            rd_almost_empty_o <= 1'b1;
            wr_full_o         <= 1'b0;
            wr_almost_full_o  <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_accept) rd_ptr <= rd_ptr + ADDR_W'(1);
            count_q           <= count_next;
            rd_empty_o        <= (count_next == '0);
            rd_almost_empty_o <= (count_next <= CNT_W'(AE_LEVEL));
            wr_full_o         <= (count_next == CNT_W'(DEPTH));
            wr_almost_full_o  <= (count_next >= CNT_W'(AF_LEVEL));
        end
    end

    assign count_o = count_q;

    // Storage is not reset; a flush leaves contents untouched.
    always_ff @(posedge clk_i) begin
        if (wr_accept && !clr_i) mem[wr_ptr] <= wr_data_i;
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data_o  = mem[rd_ptr];
        assign rd_valid_o = !rd_empty_o;
    end else begin : g_reg_read
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (clr_i) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_accept;
                if (rd_accept) rd_data_q <= mem[rd_ptr];
            end
        end

        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clr_i) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_dv_i && wr_full_o)  overflow_o  <= 1'b1;
            if (rd_en_i && rd_empty_o) underflow_o <= 1'b1;
        end
    end
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo -- randomized self-checking bench for sync_fifo.
// Drives one FWFT=1 and one FWFT=0 instance (DEPTH=8, AF=6, AE=2) with the
// same stimulus and compares both against a queue-based reference model.

module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       wr_dv;
    logic [7:0] wr_data;
    logic       rd_en;

    logic       full_a, afull_a, valid_a, empty_a, aempty_a, ovf_a, unf_a;
    logic [7:0] rdata_a;
    logic [3:0] count_a;
    logic       full_b, afull_b, valid_b, empty_b, aempty_b, ovf_b, unf_b;
    logic [7:0] rdata_b;
    logic [3:0] count_b;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state
    logic [7:0] q[$];
    logic       m_ovf;
    logic       m_unf;
    logic [7:0] m_rdata_r;
    logic       m_rvalid_r;

    sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wr_dv_i(wr_dv), .wr_data_i(wr_data),
        .wr_full_o(full_a), .wr_almost_full_o(afull_a),
        .rd_en_i(rd_en), .rd_data_o(rdata_a), .rd_valid_o(valid_a),
        .rd_empty_o(empty_a), .rd_almost_empty_o(aempty_a),
        .count_o(count_a), .overflow_o(ovf_a), .underflow_o(unf_a)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_reg (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .wr_dv_i(wr_dv), .wr_data_i(wr_data),
        .wr_full_o(full_b), .wr_almost_full_o(afull_b),
        .rd_en_i(rd_en), .rd_data_o(rdata_b), .rd_valid_o(valid_b),
        .rd_empty_o(empty_b), .rd_almost_empty_o(aempty_b),
        .count_o(count_b), .overflow_o(ovf_b), .underflow_o(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_err(input logic v);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        m_rdata_r  = 8'h00;
        m_rvalid_r = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = q.size();
        check({tag, ".count"},  32'(count_a), n);
        check({tag, ".empty"},  32'(empty_a), 32'(n == 0));
        check({tag, ".full"},   32'(full_a),  32'(n == 8));
        check({tag, ".afull"},  32'(afull_a), 32'(n >= 6));
        check({tag, ".aempty"}, 32'(aempty_a), 32'(n <= 2));
        check({tag, ".valid"},  32'(valid_a), 32'(n != 0));
        if (n != 0) check({tag, ".data"}, 32'(rdata_a), 32'(q[0]));
        check({tag, ".ovf"},    32'(ovf_a), 32'(exp_err(m_ovf)));
        check({tag, ".unf"},    32'(unf_a), 32'(exp_err(m_unf)));
        check({tag, ".r_count"}, 32'(count_b), n);
        check({tag, ".r_valid"}, 32'(valid_b), 32'(m_rvalid_r));
        check({tag, ".r_data"},  32'(rdata_b), 32'(m_rdata_r));
        check({tag, ".r_ovf"},   32'(ovf_b), 32'(exp_err(m_ovf)));
    endtask

    // One clock: apply inputs, clock, update model from pre-edge state, check.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        logic was_full, was_empty;
        wr_dv = w; wr_data = d; rd_en = r; clr = c;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        @(posedge clk); #1;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rvalid_r = 1'b0;
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            m_rvalid_r = 1'b0;
            if (r && !was_empty) begin
                m_rdata_r  = q.pop_front();
                m_rvalid_r = 1'b1;
            end
            if (w && !was_full) q.push_back(d);
        end
        wr_dv = 1'b0; rd_en = 1'b0; clr = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b1; clr = 1'b0; wr_dv = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // In-order fill and drain with flag thresholds
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)  step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // Write when full is dropped
        for (int i = 0; i < 8; i++) step("fill2", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous read+write at full and at empty
        for (int i = 0; i < 8; i++) step("fill3", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step("rw_full", 1'b1, 8'h33, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("drain3", 1'b0, 8'h00, 1'b1, 1'b0);
        step("rw_empty", 1'b1, 8'h44, 1'b1, 1'b0);
        step("drain4", 1'b0, 8'h00, 1'b1, 1'b0);
        step("unf", 1'b0, 8'h00, 1'b1, 1'b0);

        // Interleaved traffic across pointer wrap
        for (int i = 0; i < 24; i++) step("wrap", 1'b1, 8'(8'h40 + i), (i % 3) != 0, 1'b0);
        for (int i = 0; i < 12; i++) step("wrap_dr", 1'b0, 8'h00, 1'b1, 1'b0);

        // Registered-read pulse on a single word
        step("clr0", 1'b0, 8'h00, 1'b0, 1'b1);
        step("w5c", 1'b1, 8'h5C, 1'b0, 1'b0);
        step("r5c", 1'b0, 8'h00, 1'b1, 1'b0);
        step("r5c_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with drifting bias and occasional flush
        for (int i = 0; i < 400; i++) begin
            int unsigned wp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            step("rand", $urandom_range(0, 99) < wp, 8'($urandom),
                 $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 59) == 0);
        end

        // Flush overrides a same-cycle write
        step("clr1", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("fill5", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step("clr_wr", 1'b1, 8'hEE, 1'b0, 1'b1);
        step("post_clr", 1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-burst, no clock edge required
        for (int i = 0; i < 4; i++) step("burst", 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        step("burst_ovf", 1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step("after_rst_w", 1'b1, 8'h77, 1'b0, 1'b0);
        step("after_rst_w2", 1'b1, 8'h78, 1'b0, 1'b0);
        step("after_rst_r", 1'b0, 8'h00, 1'b1, 1'b0);
        step("after_rst_r2", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
